// File: rtl/sim_ctrl.sv
// Simulation-control block: snoops MMIO console/exit writes, buffers console bytes,
// runs a PC-stall watchdog and address-range checks, and reports a sticky halt.
module sim_ctrl #(
    parameter logic [31:0] PUTC_ADDR  = 32'h8000001c,
    parameter logic [31:0] EXIT_ADDR  = 32'h8000002c,
    parameter int unsigned IRAMSIZE   = 131072,
    parameter int unsigned DRAMSIZE   = 131072,
    parameter int unsigned TIMEOUT    = 100,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic [31:0]      if_pc,
    input  logic             retire,
    input  logic             exception,
    input  logic             imem_ready,
    input  logic [31:0]      imem_addr,
    input  logic             dmem_wready,
    input  logic [31:0]      dmem_waddr,
    input  logic [31:0]      dmem_wdata,
    input  logic [3:0]       dmem_wstrb,
    output logic             tx_valid,
    output logic [7:0]       tx_data,
    input  logic             tx_ready,
    output logic             halt,
    output logic [2:0]       halt_code,
    output logic [31:0]      halt_info,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt,
    output logic [15:0]      drop_cnt
);

    localparam int unsigned IA_W  = $clog2(IRAMSIZE);
    localparam int unsigned DA_W  = $clog2(IRAMSIZE + DRAMSIZE);
    localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam int unsigned SC_W  = $clog2(TIMEOUT + 2);
    localparam logic [SC_W-1:0] TIMEOUT_V = SC_W'(TIMEOUT);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    localparam logic [2:0] CODE_EXIT = 3'd1;
    localparam logic [2:0] CODE_TMO  = 3'd2;
    localparam logic [2:0] CODE_EXC  = 3'd3;
    localparam logic [2:0] CODE_IMEM = 3'd4;
    localparam logic [2:0] CODE_DMEM = 3'd5;

    logic [1:0]       state_q, state_d;
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;
    logic [2:0]       halt_code_q, halt_code_d;
    logic [31:0]      halt_info_q, halt_info_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instret_cnt_q, instret_cnt_d;
    logic [31:0]      last_pc_q, last_pc_d;
    logic [SC_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [7:0]       mem_q [FIFO_DEPTH];

    logic empty, full, pop, push, push_req, drop, run;
    logic exit_hit, imem_bad, dmem_bad, pc_same, timeout_hit;
    logic unused_strb;

    assign unused_strb = ^dmem_wstrb[3:1];

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[IDX_W] != rd_q[IDX_W]) && (wr_q[IDX_W-1:0] == rd_q[IDX_W-1:0]);
    assign run   = (state_q == ST_RUN);

    assign tx_valid    = !empty;
    assign tx_data     = empty ? 8'h00 : mem_q[rd_q[IDX_W-1:0]];
    assign halt        = (state_q == ST_HALT);
    assign halt_code   = halt_code_q;
    assign halt_info   = halt_info_q;
    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
    assign drop_cnt    = drop_cnt_q;

    always_comb begin
        pop      = tx_valid && tx_ready;
        push_req = run && dmem_wready && (dmem_waddr == PUTC_ADDR) && dmem_wstrb[0];
        // A full FIFO still accepts a byte when the head leaves on the same edge
        push     = push_req && (!full || pop);
        drop     = push_req && full && !pop;

        exit_hit    = dmem_wready && (dmem_waddr == EXIT_ADDR);
        imem_bad    = imem_ready && ((imem_addr >> IA_W) != 32'd0);
        dmem_bad    = dmem_wready && (dmem_waddr != PUTC_ADDR) && (dmem_waddr != EXIT_ADDR)
                      && ((dmem_waddr >> DA_W) != 32'd0);
        pc_same     = (if_pc == last_pc_q);
        timeout_hit = pc_same && (stall_cnt_q == TIMEOUT_V);

        state_d       = state_q;
        wr_d          = push ? wr_q + PTR_W'(1) : wr_q;
        rd_d          = pop  ? rd_q + PTR_W'(1) : rd_q;
        drop_cnt_d    = (drop && (drop_cnt_q != 16'hffff)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
        halt_code_d   = halt_code_q;
        halt_info_d   = halt_info_q;
        cycle_cnt_d   = cycle_cnt_q;
        instret_cnt_d = instret_cnt_q;
        last_pc_d     = last_pc_q;
        stall_cnt_d   = stall_cnt_q;

        case (state_q)
            ST_RUN: begin
                cycle_cnt_d   = cycle_cnt_q + CNT_W'(1);
                instret_cnt_d = instret_cnt_q + CNT_W'(retire);
                last_pc_d     = if_pc;
                stall_cnt_d   = pc_same ? stall_cnt_q + SC_W'(1) : '0;
                if (exception) begin
                    halt_code_d = CODE_EXC;
                    halt_info_d = if_pc;
                    state_d     = ST_DRAIN;
                end else if (imem_bad) begin
                    halt_code_d = CODE_IMEM;
                    halt_info_d = imem_addr;
                    state_d     = ST_DRAIN;
                end else if (dmem_bad) begin
                    halt_code_d = CODE_DMEM;
                    halt_info_d = dmem_waddr;
                    state_d     = ST_DRAIN;
                end else if (exit_hit) begin
                    halt_code_d = CODE_EXIT;
                    halt_info_d = dmem_wdata;
                    state_d     = ST_DRAIN;
                end else if (timeout_hit) begin
                    halt_code_d = CODE_TMO;
                    halt_info_d = if_pc;
                    state_d     = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (empty) state_d = ST_HALT;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge resetb) begin
        if (resetb) begin
            state_q       <= ST_RUN;
            wr_q          <= '0;
            rd_q          <= '0;
            drop_cnt_q    <= '0;
            halt_code_q   <= '0;
            halt_info_q   <= '0;
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
            last_pc_q     <= '0;
            stall_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            wr_q          <= wr_d;
            rd_q          <= rd_d;
            drop_cnt_q    <= drop_cnt_d;
            halt_code_q   <= halt_code_d;
            halt_info_q   <= halt_info_d;
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
            last_pc_q     <= last_pc_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    // Storage needs no reset: tx_data is masked whenever the FIFO is empty
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[IDX_W-1:0]] <= dmem_wdata[7:0];
    end

endmodule

// File: doc/sim_ctrl.md
Name: sim_ctrl

Overview:
Synthesizable simulation-control block for the three-stage RISC-V core. It replaces bench-side MMIO handling with RTL.
- Snoops the data-memory write port and decodes the PUTC and EXIT MMIO addresses.
- Buffers console characters in a FIFO that drains over a ready/valid byte stream.
- Runs a PC-stall watchdog and checks IMEM/DMEM address ranges.
- Counts cycles and retired instructions.
- Reports a sticky halt with a cause code, so benches and FPGA wrappers share one termination mechanism.

Parameters:
PUTC_ADDR, 32'h8000001c, MMIO console byte address
EXIT_ADDR, 32'h8000002c, MMIO program-exit address
IRAMSIZE, 131072, instruction RAM bytes (power of two)
DRAMSIZE, 131072, data RAM bytes (IRAMSIZE+DRAMSIZE power of two)
TIMEOUT, 100, consecutive unchanged-PC cycles before timeout
FIFO_DEPTH, 16, console FIFO entries (power of two, >=2)
CNT_W, 32, cycle/instret counter width

Ports:
clk  in  1  clock, all state on rising edge
resetb  in  1  asynchronous, active-high reset (1 = reset)
if_pc  in  32  current fetch PC
retire  in  1  one instruction retired this cycle
exception  in  1  core exception
imem_ready  in  1  instruction fetch request
imem_addr  in  32  fetch address
dmem_wready  in  1  data write strobe
dmem_waddr  in  32  data write address
dmem_wdata  in  32  data write value
dmem_wstrb  in  4  byte enables
tx_valid  out  1  console byte available
tx_data  out  8  console byte (FIFO head)
tx_ready  in  1  consumer accepts byte
halt  out  1  sticky terminated flag
halt_code  out  3  0 none, 1 exit, 2 timeout, 3 exception, 4 imem range, 5 dmem range
halt_info  out  32  exit value (dmem_wdata) or offending address
cycle_cnt  out  CNT_W  cycles spent in RUN
instret_cnt  out  CNT_W  retires counted in RUN
drop_cnt  out  16  console bytes dropped on full FIFO, saturating

Behaviour:
- Reset: state=RUN; FIFO empty; tx_valid=0; tx_data=0; halt=0; halt_code=0; halt_info=0; all counters=0; last_pc=0; stall_cnt=0. Reset mid-DRAIN/HALT returns to RUN with everything cleared.
- FSM RUN -> DRAIN -> HALT. HALT exits only on reset.
- RUN:
  - On a termination event, latch halt_code and halt_info on that edge and enter DRAIN.
  - Termination events, in priority order: exception > imem range > dmem range > exit > timeout.
  - halt_info for exception is if_pc.
- DRAIN: no new pushes; counters frozen; watchdog frozen. Enter HALT on the edge after the FIFO is empty, or when the FIFO is empty on DRAIN entry. halt=1 from HALT onward.
- PUTC: in RUN, dmem_wready && dmem_waddr==PUTC_ADDR && dmem_wstrb[0] pushes dmem_wdata[7:0]. This includes the cycle a termination event is detected.
- Push when full with no pop in the same cycle: byte dropped, drop_cnt++ (saturates at 16'hffff). Full with simultaneous pop: push accepted.
- Console output: first-word-fall-through. tx_valid = !empty; tx_data = head, 0 when empty. Pop when tx_valid && tx_ready. Pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by an extra pointer bit. Push to an empty FIFO is visible on tx_valid the next cycle.
- EXIT: dmem_wready && dmem_waddr==EXIT_ADDR -> code 1, halt_info=dmem_wdata.
- IMEM range: imem_ready && imem_addr[31:log2(IRAMSIZE)]!=0 -> code 4, halt_info=imem_addr.
- DMEM range: dmem_wready && waddr not PUTC_ADDR/EXIT_ADDR && waddr[31:log2(IRAMSIZE+DRAMSIZE)]!=0 -> code 5, halt_info=waddr.
- Watchdog: each RUN edge, last_pc<=if_pc. stall_cnt<=stall_cnt+1 if if_pc==last_pc, else 0. Timeout fires on the edge where stall_cnt==TIMEOUT && if_pc==last_pc. halt_info=if_pc.
- Counters: cycle_cnt +1 every RUN cycle; instret_cnt +1 on retire in RUN. Both wrap modulo 2^CNT_W.

Test Plan:
- Bytes 0x48,0x69 written to PUTC_ADDR with wstrb=4'h1, tx_ready=1 -> tx_data 0x48 then 0x69 on consecutive cycles. Write with wstrb=4'h2 -> no push.
- tx_ready=0, 18 PUTC writes, FIFO_DEPTH=16 -> drop_cnt=2. Raise tx_ready -> first 16 bytes emerge in order, tx_valid then drops.
- Three queued bytes, then EXIT write of 32'h2a -> DRAIN. With tx_ready=1, halt=1 one cycle after the third pop; halt_code=1, halt_info=32'h2a; cycle_cnt frozen.
- TIMEOUT=4, if_pc held 0x40 from edge 1 -> halt_code=2 latched at edge 6; halt=1 after edge 7; halt_info=0x40.
- exception and EXIT write in the same cycle -> halt_code=3. DMEM write to 0x00080000 -> halt_code=5, halt_info=0x00080000.
- resetb pulsed high during DRAIN with 5 bytes queued -> tx_valid=0, halt=0, all counters 0, RUN resumes.
